list_prefetch_cache: RTL and testbench
======================================

# list_prefetch_cache

Parametrised prefetch buffer between the DMA list stream and a consuming IP core. Accepts a list of `LIST_LEN` elements from the DMA over a valid/ready handshake and holds them in a `DEPTH`-entry circular scratchpad. Presents them in order to the IP over a second valid/ready handshake, then pulses `DONE`. Successor to the fixed 4-entry list cache: adds configurable depth, width and list length, backpressure on both sides, flush, and an occupancy output.

## Interface
- `TYPE_WIDTH`, 32, element width in bits.
- `DEPTH`, 4, scratchpad entries; power of two, ≥ 2.
- `LEN_WIDTH`, 16, width of the list-length field.
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: reset, asynchronous assert, active-low.
- `START` in 1: begin a list; sampled only in IDLE.
- `LIST_LEN` in LEN_WIDTH: element count, captured with `START`.
- `FLUSH` in 1: synchronous abort to IDLE.
- `LIST_IN` in TYPE_WIDTH: DMA element.
- `LIST_IN_VALID` in 1: DMA element valid.
- `LIST_IN_READY` out 1: block can accept an element.
- `ARG_OUT` out TYPE_WIDTH: head element to the IP.
- `ARG_VALID` out 1: `ARG_OUT` valid.
- `ARG_READY` in 1: IP consumes the head element.
- `BUSY` out 1: state is not IDLE.
- `DONE` out 1: one-cycle pulse when the last element has been consumed.
- `LEVEL` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- **States:** IDLE, STREAM, DONE.
- **IDLE:**
  - On `START`: capture `LIST_LEN` into `in_rem` and `out_rem`.
  - If `LIST_LEN` = 0, go to DONE; otherwise go to STREAM.
- **STREAM:**
  - Push when `LIST_IN_VALID` and `LIST_IN_READY`:
    - write `LIST_IN` to `mem[wr_ptr]`;
    - `wr_ptr` += 1, wrapping modulo DEPTH;
    - `in_rem` -= 1.
  - Pop when `ARG_VALID` and `ARG_READY`:
    - `rd_ptr` += 1, wrapping modulo DEPTH;
    - `out_rem` -= 1.
  - When a pop makes `out_rem` reach 0, go to DONE.
- **DONE:** lasts exactly one cycle, with `DONE` = 1, then returns to IDLE.
- **Combinational outputs:**
  - `LIST_IN_READY` = (state == STREAM) && (`LEVEL` < DEPTH) && (`in_rem` != 0).
  - `LIST_IN_READY` has no combinational dependence on `ARG_READY`. When full, a simultaneous pop does not open the input in that cycle.
  - `ARG_VALID` = (`LEVEL` != 0).
  - `ARG_OUT` = `mem[rd_ptr]` when `ARG_VALID`, otherwise all zeros.
- **Occupancy:** simultaneous push and pop leave `LEVEL` unchanged and move both pointers.
- **Excess DMA data:** elements beyond `LIST_LEN` are never accepted, because READY is low once `in_rem` = 0.
- **`START` outside IDLE:** ignored; no state change and no error.
- **`FLUSH` (any state):**
  - next state IDLE; pointers, `LEVEL`, `in_rem` and `out_rem` go to 0;
  - no `DONE` pulse;
  - takes priority over push, pop and `START` in the same cycle.
- **Width rules:** pointers are $clog2(DEPTH) bits and wrap naturally. `LEVEL` has one extra bit so that full (DEPTH) and empty (0) are distinguishable.

## Timing
- **Reset values (`RESET_N` low, asynchronous):**
  - state IDLE; pointers 0, `LEVEL` 0, `in_rem` 0, `out_rem` 0;
  - `LIST_IN_READY` 0, `ARG_VALID` 0, `ARG_OUT` 0, `BUSY` 0, `DONE` 0.
- **Reset mid-list:** identical to the above; buffered data is discarded.
- **Memory:** scratchpad contents are not reset.
- **`START` latency:** `START` at edge N makes `BUSY` and `LIST_IN_READY` high after edge N.
- **Pass-through latency:** an element pushed at edge N appears on `ARG_OUT` with `ARG_VALID` after edge N (1 cycle). There is no same-cycle bypass.
- **Throughput:** one push and one pop per cycle, sustained while 0 < `LEVEL` < DEPTH.
- **`DONE` timing:** the pop of the last element at edge N makes `DONE` high for the cycle after edge N and `BUSY` low after edge N+1.
- **Zero-length list:** `START` with `LIST_LEN` = 0 at edge N pulses `DONE` after edge N.
- **Back-to-back lists:** `START` is accepted in the cycle IDLE is re-entered, i.e. the cycle after `DONE`.

## Test plan
1. **Single list, free-running consumer.** Reset; `START`, `LIST_LEN`=6, DEPTH=4, values 0x10..0x15, `ARG_READY`=1 throughout.
   → `ARG_OUT` shows 0x10..0x15 in order, each one cycle after its push. `DONE` pulses once. `LEVEL` never exceeds 1.
2. **Backpressure to full.** `LIST_LEN`=8, `ARG_READY`=0 until `LEVEL`=4.
   → `LIST_IN_READY` drops at `LEVEL`=4 with no element lost. Assert `ARG_READY` and hold `LIST_IN_VALID`: the push resumes one cycle after the first pop, so `LEVEL` goes to 3 and then stays at 3 under simultaneous push/pop. The pointers wrap, and all 8 values (0xA0..0xA7) arrive in order.
3. **Zero length and ignored `START`.** `START` with `LIST_LEN`=0.
   → `DONE` pulses after one edge and `LIST_IN_READY` never rises. Then `START` `LIST_LEN`=3, and `START` again mid-list with `LIST_LEN`=9.
   → exactly 3 elements are accepted and delivered.
4. **Excess DMA data.** `LIST_LEN`=2, DMA holds `LIST_IN_VALID`=1 continuously.
   → exactly 2 handshakes occur, then `LIST_IN_READY`=0 until the next `START`.
5. **`FLUSH` and reset mid-list.** `LIST_LEN`=5 with 3 elements buffered; assert `FLUSH` for one cycle together with `ARG_READY`.
   → next cycle: IDLE, `LEVEL`=0, `ARG_VALID`=0, no `DONE`. Repeat the setup and drive `RESET_N` low between edges.
   → outputs go to their reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/list_prefetch_cache.sv
// list_prefetch_cache: DMA list prefetch buffer in front of a consuming IP.
// Takes LIST_LEN elements from the DMA, holds them in a DEPTH-entry circular
// scratchpad and hands them to the IP in order, then pulses DONE.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START; LIST_LEN captured on START
// S_STREAM | accepting DMA elements and delivering them to the IP
// S_DONE   | one-cycle DONE pulse after the last element was consumed
module list_prefetch_cache #(
  parameter int TYPE_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      START,
  input  logic [LEN_WIDTH-1:0]      LIST_LEN,
  input  logic                      FLUSH,
  input  logic [TYPE_WIDTH-1:0]     LIST_IN,
  input  logic                      LIST_IN_VALID,
  output logic                      LIST_IN_READY,
  output logic [TYPE_WIDTH-1:0]     ARG_OUT,
  output logic                      ARG_VALID,
  input  logic                      ARG_READY,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [$clog2(DEPTH):0]    LEVEL
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TYPE_WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          level;
  logic [LEN_WIDTH-1:0]    in_rem, out_rem;
  logic                    push, pop, start_take;

  // Handshake qualifiers; FLUSH overrides every transfer in its cycle.
  always_comb begin
    LIST_IN_READY = (state_q == S_STREAM) && (level < FULL_LEVEL) && (in_rem != '0);
    ARG_VALID     = (level != '0);
    ARG_OUT       = ARG_VALID ? mem[rd_ptr] : '0;
    push          = LIST_IN_VALID && LIST_IN_READY && !FLUSH;
    pop           = ARG_VALID && ARG_READY && !FLUSH;
    start_take    = (state_q == S_IDLE) && START && !FLUSH;
    BUSY          = (state_q != S_IDLE);
    DONE          = (state_q == S_DONE);
    LEVEL         = level;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (START) state_d = (LIST_LEN == '0) ? S_DONE : S_STREAM;
        S_STREAM: if (pop && (out_rem == LEN_WIDTH'(1))) state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Pointers, occupancy and remaining-element counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      in_rem  <= '0;
      out_rem <= '0;
    end else if (FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      in_rem  <= '0;
      out_rem <= '0;
    end else begin
      if (start_take) begin
        in_rem  <= LIST_LEN;
        out_rem <= LIST_LEN;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        in_rem <= in_rem - 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_rem <= out_rem - 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Scratchpad write port; contents are intentionally left unreset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= LIST_IN;
  end

endmodule

// File: tb/tb_list_prefetch_cache.sv
// Bench for list_prefetch_cache: DMA driver and IP-side monitor run as
// separate processes; expected elements are queued when a list is issued.
module tb_list_prefetch_cache;

  localparam int TW = 32;
  localparam int DEPTH = 4;
  localparam int LW = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START = 1'b0;
  logic [LW-1:0] LIST_LEN = '0;
  logic          FLUSH = 1'b0;
  logic [TW-1:0] LIST_IN = '0;
  logic          LIST_IN_VALID = 1'b0;
  logic          LIST_IN_READY;
  logic [TW-1:0] ARG_OUT;
  logic          ARG_VALID;
  logic          ARG_READY = 1'b0;
  logic          BUSY;
  logic          DONE;
  logic [$clog2(DEPTH):0] LEVEL;

  list_prefetch_cache #(.TYPE_WIDTH(TW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .LIST_LEN(LIST_LEN),
    .FLUSH(FLUSH), .LIST_IN(LIST_IN), .LIST_IN_VALID(LIST_IN_VALID),
    .LIST_IN_READY(LIST_IN_READY), .ARG_OUT(ARG_OUT), .ARG_VALID(ARG_VALID),
    .ARG_READY(ARG_READY), .BUSY(BUSY), .DONE(DONE), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] dma_q[$];
  bit dma_hold = 1'b0;
  int push_cnt = 0, pop_cnt = 0, done_cnt = 0, rdy_cnt = 0, max_level = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // DMA side: present queue head (or filler when holding VALID), count handshakes.
  initial forever begin
    @(negedge CLK);
    if (dma_q.size() > 0) begin
      LIST_IN_VALID = 1'b1;
      LIST_IN = dma_q[0];
    end else begin
      LIST_IN_VALID = dma_hold;
      LIST_IN = 32'hEE;
    end
    #2;
    if (LIST_IN_VALID && LIST_IN_READY && !FLUSH && RESET_N) begin
      if (dma_q.size() > 0) void'(dma_q.pop_front());
      push_cnt++;
    end
  end

  // IP side monitor: every handshake is compared with the scoreboard head.
  initial forever begin
    logic [TW-1:0] e;
    @(negedge CLK);
    #2;
    if (ARG_VALID && ARG_READY && !FLUSH && RESET_N) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL arg_out_unexpected: got %0h, expected no element", ARG_OUT);
      end else begin
        e = exp_q.pop_front();
        check("arg_out", ARG_OUT, e);
      end
    end
    if (DONE) done_cnt++;
    if (int'(LEVEL) > max_level) max_level = int'(LEVEL);
    if (LIST_IN_READY) rdy_cnt++;
  end

  task automatic start_list(input int len, input bit chk);
    @(negedge CLK);
    START = 1'b1;
    LIST_LEN = LW'(len);
    @(negedge CLK);
    START = 1'b0;
    #3;
    if (chk) begin
      check("start_busy", BUSY, 1'b1);
      check("start_ready", LIST_IN_READY, (len != 0));
    end
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #3;
      if (done_cnt >= target) break;
    end
    check(name, done_cnt, target);
    @(negedge CLK);
    #3;
    check({name, "_busy_low"}, BUSY, 1'b0);
  endtask

  task automatic wait_level(input int lvl, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      #3;
      if (int'(LEVEL) == lvl) break;
    end
    check(name, LEVEL, lvl);
  endtask

  initial begin
    int pb, qb, rb;
    // Reset values
    #3;
    check("rst_ready", LIST_IN_READY, 1'b0);
    check("rst_valid", ARG_VALID, 1'b0);
    check("rst_argout", ARG_OUT, 32'h0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_level", LEVEL, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // 1: single list, free-running consumer
    ARG_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'h10 + i);
      dma_q.push_back(32'h10 + i);
    end
    max_level = 0;
    start_list(6, 1'b1);
    wait_done(1, "t1_done");
    check("t1_max_level", max_level, 1);
    check("t1_pops", pop_cnt, 6);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: backpressure to full, then sustained push/pop at level 3
    ARG_READY = 1'b0;
    pb = push_cnt;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'hA0 + i);
      dma_q.push_back(32'hA0 + i);
    end
    start_list(8, 1'b1);
    wait_level(4, "t2_full");
    check("t2_ready_full", LIST_IN_READY, 1'b0);
    @(negedge CLK);
    #3;
    check("t2_level_hold", LEVEL, 4);
    check("t2_pushes_full", push_cnt - pb, 4);
    @(negedge CLK);
    ARG_READY = 1'b1;
    #3;
    check("t2_ready_no_bypass", LIST_IN_READY, 1'b0);
    @(negedge CLK);
    #3;
    check("t2_level_after_pop", LEVEL, 3);
    check("t2_ready_reopen", LIST_IN_READY, 1'b1);
    @(negedge CLK);
    #3;
    check("t2_level_steady", LEVEL, 3);
    wait_done(2, "t2_done");
    check("t2_pushes", push_cnt - pb, 8);
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: zero length, then a list with an ignored mid-list START
    rb = rdy_cnt;
    start_list(0, 1'b0);
    check("t3_zero_done", DONE, 1'b1);
    @(negedge CLK);
    #3;
    check("t3_zero_done_cnt", done_cnt, 3);
    check("t3_zero_no_ready", rdy_cnt - rb, 0);
    pb = push_cnt;
    qb = pop_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h31 + i);
      dma_q.push_back(32'h31 + i);
    end
    start_list(3, 1'b1);
    for (int i = 0; i < 9; i++) dma_q.push_back(32'h90 + i);
    start_list(9, 1'b0);
    wait_done(4, "t3_done");
    check("t3_pushes", push_cnt - pb, 3);
    check("t3_pops", pop_cnt - qb, 3);
    dma_q.delete();

    // 4: excess DMA data with VALID held high
    pb = push_cnt;
    dma_hold = 1'b1;
    exp_q.push_back(32'h41);
    exp_q.push_back(32'h42);
    dma_q.push_back(32'h41);
    dma_q.push_back(32'h42);
    start_list(2, 1'b1);
    wait_done(5, "t4_done");
    repeat (3) @(negedge CLK);
    #3;
    check("t4_pushes", push_cnt - pb, 2);
    check("t4_ready_low", LIST_IN_READY, 1'b0);
    dma_hold = 1'b0;

    // 5a: FLUSH with three elements buffered
    ARG_READY = 1'b0;
    for (int i = 0; i < 3; i++) dma_q.push_back(32'h51 + i);
    start_list(5, 1'b1);
    wait_level(3, "t5_level3");
    @(negedge CLK);
    FLUSH = 1'b1;
    ARG_READY = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    ARG_READY = 1'b0;
    #3;
    check("t5_flush_busy", BUSY, 1'b0);
    check("t5_flush_level", LEVEL, 0);
    check("t5_flush_valid", ARG_VALID, 1'b0);
    check("t5_flush_done", DONE, 1'b0);
    @(negedge CLK);
    #3;
    check("t5_flush_no_done", done_cnt, 5);

    // 5b: asynchronous reset mid-list
    for (int i = 0; i < 3; i++) dma_q.push_back(32'h71 + i);
    start_list(5, 1'b1);
    wait_level(3, "t5_level3_again");
    #1;
    RESET_N = 1'b0;
    #1;
    check("t5_rst_level", LEVEL, 0);
    check("t5_rst_valid", ARG_VALID, 1'b0);
    check("t5_rst_argout", ARG_OUT, 32'h0);
    check("t5_rst_busy", BUSY, 1'b0);
    check("t5_rst_ready", LIST_IN_READY, 1'b0);
    check("t5_rst_done", DONE, 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    dma_q.delete();

    // Recovery list after reset
    ARG_READY = 1'b1;
    exp_q.push_back(32'h61);
    exp_q.push_back(32'h62);
    dma_q.push_back(32'h61);
    dma_q.push_back(32'h62);
    start_list(2, 1'b1);
    wait_done(6, "t6_done");
    check("t6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
